// File: rtl/psg_register_file.sv
// SN76489-style write decoder and register bank: latch/data byte protocol, tone/atten/noise registers.
// Optional READY busy handshake is built only when PSG_READY_EN is defined.
module psg_register_file #(
    parameter int unsigned READY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we_n,
    input  logic [7:0] data,
    output logic       ready,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] atten0,
    output logic [3:0] atten1,
    output logic [3:0] atten2,
    output logic [3:0] atten3,
    output logic [2:0] noise_ctrl,
    output logic       noise_restart
);

    logic       accept;
    logic [2:0] latch_q;
    logic [2:0] addr;
    logic [9:0] tone_q  [3];
    logic [3:0] atten_q [4];

    assign accept = ~we_n & ready;
    // A latch byte carries its own address; a data byte reuses the stored one.
    assign addr   = data[7] ? data[6:4] : latch_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch_q       <= 3'b000;
            tone_q[0]     <= '0;
            tone_q[1]     <= '0;
            tone_q[2]     <= '0;
            atten_q[0]    <= 4'hF;
            atten_q[1]    <= 4'hF;
            atten_q[2]    <= 4'hF;
            atten_q[3]    <= 4'hF;
            noise_ctrl    <= 3'b000;
            noise_restart <= 1'b0;
        end else begin
            noise_restart <= 1'b0;
            if (accept) begin
                if (data[7]) latch_q <= addr;
                case (addr)
                    3'b000, 3'b010, 3'b100: begin
                        if (data[7]) tone_q[addr[2:1]][3:0] <= data[3:0];
                        else         tone_q[addr[2:1]][9:4] <= data[5:0];
                    end
                    3'b110: begin
                        noise_ctrl    <= data[2:0];
                        noise_restart <= 1'b1;
                    end
                    default: atten_q[addr[2:1]] <= data[3:0];
                endcase
            end
        end
    end

    assign tone0  = tone_q[0];
    assign tone1  = tone_q[1];
    assign tone2  = tone_q[2];
    assign atten0 = atten_q[0];
    assign atten1 = atten_q[1];
    assign atten2 = atten_q[2];
    assign atten3 = atten_q[3];

`ifdef PSG_READY_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = 8'(READY_CYCLES);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_d == 8'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
`else
    logic unused_ready_cycles;
    assign unused_ready_cycles = ^READY_CYCLES;
    assign ready = 1'b1;
`endif

endmodule

// File: tb/tb_psg_register_file.sv
// Directed bench for psg_register_file: behavioural register-bank model checked every cycle,
// plus literal expectations; busy-handshake checks are built when PSG_READY_EN is defined.
module tb_psg_register_file;

    localparam int RC = 32;
`ifdef PSG_READY_EN
    localparam bit READY_EN = 1'b1;
`else
    localparam bit READY_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       we_n    = 1'b1;
    logic [7:0] data    = 8'h00;
    logic       ready;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] atten0, atten1, atten2, atten3;
    logic [2:0] noise_ctrl;
    logic       noise_restart;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    psg_register_file #(.READY_CYCLES(RC)) dut (
        .clk(clk), .reset_n(reset_n), .we_n(we_n), .data(data), .ready(ready),
        .tone0(tone0), .tone1(tone1), .tone2(tone2),
        .atten0(atten0), .atten1(atten1), .atten2(atten2), .atten3(atten3),
        .noise_ctrl(noise_ctrl), .noise_restart(noise_restart)
    );

    // Behavioural model: plain arrays indexed by channel, busy time as a remaining-cycle count.
    int tone_m  [3] = '{0, 0, 0};
    int atten_m [4] = '{15, 15, 15, 15};
    int noise_m     = 0;
    int latch_m     = 0;
    int restart_m   = 0;
    int busy_m      = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) tone_m[i] = 0;
        for (int i = 0; i < 4; i++) atten_m[i] = 15;
        noise_m = 0; latch_m = 0; restart_m = 0; busy_m = 0;
    endtask

    task automatic model_write(input int d);
        int a;
        int ch;
        if (d >= 128) begin
            a = (d / 16) % 8;
            latch_m = a;
        end else begin
            a = latch_m;
        end
        ch = a / 2;
        if (a == 6) begin
            noise_m = d % 8;
            restart_m = 1;
        end else if (a % 2 == 1) begin
            atten_m[ch] = d % 16;
        end else if (d >= 128) begin
            tone_m[ch] = (tone_m[ch] / 16) * 16 + d % 16;
        end else begin
            tone_m[ch] = (d % 64) * 16 + tone_m[ch] % 16;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            restart_m = 0;
            if (we_n == 1'b0 && busy_m == 0) begin
                model_write(int'(data));
                if (READY_EN) busy_m = RC;
            end else if (busy_m > 0) begin
                busy_m = busy_m - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_tone0", 16'(tone0), 16'(tone_m[0]));
            chk("m_tone1", 16'(tone1), 16'(tone_m[1]));
            chk("m_tone2", 16'(tone2), 16'(tone_m[2]));
            chk("m_atten0", 16'(atten0), 16'(atten_m[0]));
            chk("m_atten1", 16'(atten1), 16'(atten_m[1]));
            chk("m_atten2", 16'(atten2), 16'(atten_m[2]));
            chk("m_atten3", 16'(atten3), 16'(atten_m[3]));
            chk("m_noise_ctrl", 16'(noise_ctrl), 16'(noise_m));
            chk("m_noise_restart", 16'(noise_restart), 16'(restart_m));
            chk("m_ready", 16'(ready), 16'(busy_m == 0));
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("ready_wait_timeout", 16'(ready), 16'd1);
    endtask

    // Called at a falling edge; returns at the falling edge of the cycle after the accept.
    task automatic wr(input logic [7:0] d);
        wait_ready();
        we_n = 1'b0;
        data = d;
        @(negedge clk);
        we_n = 1'b1;
    endtask

    initial begin
        int low;
        #1 reset_n = 1'b0;
        #2 check_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tone0", 16'(tone0), 16'h000);
        chk("rst_atten3", 16'(atten3), 16'hF);
        chk("rst_noise", 16'(noise_ctrl), 16'h0);
        chk("rst_ready", 16'(ready), 16'h1);
        reset_n = 1'b1;

        wr(8'h8E); chk("tone0_latch", 16'(tone0), 16'h00E);
        wr(8'h2A); chk("tone0_data", 16'(tone0), 16'h2AE);
        wr(8'h01); chk("tone0_retained", 16'(tone0), 16'h01E);
        wr(8'hD5); chk("atten2_latch", 16'(atten2), 16'h5);
        chk("atten2_others", 16'(tone0), 16'h01E);
        wr(8'h0C); chk("atten2_data", 16'(atten2), 16'hC);
        wr(8'hE6); chk("noise_latch", 16'(noise_ctrl), 16'h6);
        chk("restart_pulse", 16'(noise_restart), 16'h1);
        @(negedge clk); chk("restart_end", 16'(noise_restart), 16'h0);
        wr(8'h03); chk("noise_data", 16'(noise_ctrl), 16'h3);
        chk("restart_pulse2", 16'(noise_restart), 16'h1);
        wr(8'h7F); chk("noise_dontcare", 16'(noise_ctrl), 16'h7);
        wr(8'hA3); wr(8'h7F); chk("tone1_dontcare", 16'(tone1), 16'h3F3);
        wr(8'hC9); wr(8'h40); chk("tone2", 16'(tone2), 16'h009);
        wr(8'hFA); chk("atten3", 16'(atten3), 16'hA);
        wr(8'h31); chk("atten3_data", 16'(atten3), 16'h1);

`ifndef PSG_READY_EN
        we_n = 1'b0; data = 8'hE4;
        @(negedge clk); data = 8'h05;
        chk("b2b_noise1", 16'(noise_ctrl), 16'h4);
        chk("b2b_pulse1", 16'(noise_restart), 16'h1);
        @(negedge clk); we_n = 1'b1;
        chk("b2b_noise2", 16'(noise_ctrl), 16'h5);
        chk("b2b_pulse2", 16'(noise_restart), 16'h1);
        @(negedge clk);
        chk("b2b_pulse_end", 16'(noise_restart), 16'h0);
`else
        wait_ready();
        we_n = 1'b0; data = 8'h9F;
        @(negedge clk); we_n = 1'b1;
        low = 0;
        for (int k = 0; k < 100; k++) begin
            if (ready === 1'b1) break;
            low++;
            if (k == 3) begin
                we_n = 1'b0; data = 8'h90;
            end else begin
                we_n = 1'b1;
            end
            @(negedge clk);
        end
        we_n = 1'b1;
        chk("busy_low_cycles", 16'(low), 16'd32);
        chk("busy_write_dropped", 16'(atten0), 16'hF);
        we_n = 1'b0; data = 8'h90;
        @(negedge clk); we_n = 1'b1;
        chk("busy_after_accept", 16'(atten0), 16'h0);
        chk("busy_ready_low", 16'(ready), 16'h0);
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("midbusy_ready", 16'(ready), 16'h1);
        chk("midbusy_atten0", 16'(atten0), 16'hF);
        @(negedge clk);
        reset_n = 1'b1; we_n = 1'b0; data = 8'h97;
        @(negedge clk); we_n = 1'b1;
        chk("midbusy_first_write", 16'(atten0), 16'h7);
`endif

        wait_ready();
        #2 reset_n = 1'b0;
        #1 chk("midrun_tone1", 16'(tone1), 16'h000);
        chk("midrun_atten2", 16'(atten2), 16'hF);
        chk("midrun_noise", 16'(noise_ctrl), 16'h0);
        chk("midrun_ready", 16'(ready), 16'h1);
        @(negedge clk);
        reset_n = 1'b1; we_n = 1'b0; data = 8'h93;
        @(negedge clk); we_n = 1'b1;
        chk("post_reset_write", 16'(atten0), 16'h3);
        repeat (3) @(negedge clk);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
